// File: rtl/rst_en_gen.sv
// Reset and clock-enable generator for one downstream clock domain.
//
// The board reset (rst) asserts asynchronously and is released through a
// short synchronizer, then stretched, before downstream flops come out of
// reset. The block also accepts a software re-reset request. It generates
// a periodic clock-enable pulse whose period is programmable.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_HOLD    | async reset seen, waiting for the release synchronizer
// ST_STRETCH | synchronizer released (or soft reset), holding reset low
// ST_RUN     | downstream out of reset, enable divider active
module rst_en_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 4,
  parameter int DIV_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_rst_req,
  input  logic             en_run,
  input  logic [DIV_W-1:0] en_div,
  output logic             rst_n_sync,
  output logic             en_out,
  output logic             ready,
  output logic             busy
);

  // The state register acts as the final synchronizer stage, so the chain
  // itself is one flop shorter than SYNC_STAGES.
  localparam int CW   = SYNC_STAGES - 1;
  localparam int SC_W = (STRETCH > 0) ? $clog2(STRETCH + 1) : 1;
  localparam logic [SC_W-1:0] STRETCH_MAX = SC_W'(STRETCH);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     chain_q, chain_d;
  logic [SC_W-1:0]   stretch_cnt_q, stretch_cnt_d;
  logic              run_q, run_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_shadow_q, div_shadow_d;

  logic              in_run;
  logic              wrap;

  assign in_run = (state_q == ST_RUN);
  assign wrap   = (cnt_q == div_shadow_q);

  // All state, including the release chain, clears asynchronously on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_HOLD;
      chain_q       <= '0;
      stretch_cnt_q <= '0;
      run_q         <= 1'b0;
      cnt_q         <= '0;
      div_shadow_q  <= '0;
    end else begin
      state_q       <= state_d;
      chain_q       <= chain_d;
      stretch_cnt_q <= stretch_cnt_d;
      run_q         <= run_d;
      cnt_q         <= cnt_d;
      div_shadow_q  <= div_shadow_d;
    end
  end

  // Release synchronizer and sequencing FSM.
  always_comb begin
    chain_d       = (chain_q << 1) | CW'(1);
    state_d       = state_q;
    stretch_cnt_d = stretch_cnt_q;
    case (state_q)
      ST_HOLD: begin
        if (chain_q[CW-1]) begin
          if (STRETCH == 0) begin
            state_d = ST_RUN;
          end else begin
            // The exit edge already counts as the first stretch cycle, so
            // the total release latency is SYNC_STAGES + STRETCH edges.
            state_d       = ST_STRETCH;
            stretch_cnt_d = SC_W'(1);
          end
        end
      end
      ST_STRETCH: begin
        if (stretch_cnt_q == STRETCH_MAX) begin
          state_d = ST_RUN;
        end else begin
          stretch_cnt_d = stretch_cnt_q + SC_W'(1);
        end
      end
      ST_RUN: begin
        // Starting from zero gives STRETCH+1 low cycles, never fewer than one.
        if (soft_rst_req) begin
          state_d       = ST_STRETCH;
          stretch_cnt_d = '0;
        end
      end
      default: begin
        state_d       = ST_HOLD;
        stretch_cnt_d = '0;
      end
    endcase
  end

  // Enable divider: count run cycles and wrap at the shadowed period.
  always_comb begin
    run_d        = en_run;
    cnt_d        = cnt_q;
    div_shadow_d = div_shadow_q;
    if (!in_run) begin
      cnt_d        = '0;
      div_shadow_d = en_div;
    end else begin
      if (run_q) begin
        if (wrap) begin
          cnt_d        = '0;
          div_shadow_d = en_div;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      // Leaving RUN restarts the period from zero on the next entry.
      if (state_d != ST_RUN) begin
        cnt_d = '0;
      end
    end
  end

  assign rst_n_sync = in_run;
  assign ready      = in_run;
  assign busy       = ~in_run;
  assign en_out     = in_run & run_q & wrap;

endmodule
